// File: rtl/alu_16bit_serial_pkg.sv
// Shared definitions for the nibble-serial 16-bit ALU: controller states and
// slice geometry.
package alu_16bit_serial_pkg;

  localparam int SLICE_W    = 4;
  localparam int NUM_SLICES = 4;
  localparam int DATA_W     = SLICE_W * NUM_SLICES;
  localparam int IDX_W      = $clog2(NUM_SLICES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_16bit_serial_alu_4bit.sv
// alu_4bit: one 4-bit ALU slice in the 74181 style (active-high data, active-high
// carry). M=1 selects a bitwise logic function; M=0 selects X plus Y plus cin,
// where X and Y are chosen from A and B by ALU_Sel. The carry machinery (cout, p, g)
// always follows the arithmetic X/Y pair, whatever the mode.
module alu_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] ALU_Sel,
  input  logic       M,
  input  logic       cin,
  output logic [3:0] F,
  output logic       cout,
  output logic       p,
  output logic       g
);

  logic [3:0] x, y, logic_f;
  logic [4:0] sum, gen;

  // Arithmetic operand pair; "minus 1" terms are expressed as adding all-ones.
  always_comb begin
    x = A;
    y = 4'h0;
    case (ALU_Sel)
      4'd0:  begin x = A;        y = 4'h0;     end
      4'd1:  begin x = A | B;    y = 4'h0;     end
      4'd2:  begin x = A | ~B;   y = 4'h0;     end
      4'd3:  begin x = 4'h0;     y = 4'hF;     end
      4'd4:  begin x = A;        y = A & ~B;   end
      4'd5:  begin x = A | B;    y = A & ~B;   end
      4'd6:  begin x = A;        y = ~B;       end
      4'd7:  begin x = A & ~B;   y = 4'hF;     end
      4'd8:  begin x = A;        y = A & B;    end
      4'd9:  begin x = A;        y = B;        end
      4'd10: begin x = A | ~B;   y = A & B;    end
      4'd11: begin x = A & B;    y = 4'hF;     end
      4'd12: begin x = A;        y = A;        end
      4'd13: begin x = A | B;    y = A;        end
      4'd14: begin x = A | ~B;   y = A;        end
      default: begin x = A;      y = 4'hF;     end
    endcase
  end

  // Logic-mode function table.
  always_comb begin
    logic_f = 4'h0;
    case (ALU_Sel)
      4'd0:  logic_f = ~A;
      4'd1:  logic_f = ~(A | B);
      4'd2:  logic_f = ~A & B;
      4'd3:  logic_f = 4'h0;
      4'd4:  logic_f = ~(A & B);
      4'd5:  logic_f = ~B;
      4'd6:  logic_f = A ^ B;
      4'd7:  logic_f = A & ~B;
      4'd8:  logic_f = ~A | B;
      4'd9:  logic_f = ~(A ^ B);
      4'd10: logic_f = B;
      4'd11: logic_f = A & B;
      4'd12: logic_f = 4'hF;
      4'd13: logic_f = A | ~B;
      4'd14: logic_f = A | B;
      default: logic_f = A;
    endcase
  end

  assign gen  = {1'b0, x} + {1'b0, y};
  assign sum  = gen + {4'b0, cin};
  assign g    = gen[4];
  assign p    = &(x ^ y);
  assign cout = sum[4];
  assign F    = M ? logic_f : sum[3:0];

endmodule

// File: rtl/alu_16bit_serial.sv
// alu_16bit_serial: 16-bit ALU built from a single alu_4bit slice reused over four
// cycles, least-significant nibble first, carry held in a register between slices.
// Optional feature: define ALU_SERIAL_EQ_EN to add the equality_check output.
module alu_16bit_serial
  import alu_16bit_serial_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [3:0]  ALU_Sel,
  input  logic        M,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [15:0] F,
  output logic        Cn4,
  output logic        P,
  output logic        G
`ifdef ALU_SERIAL_EQ_EN
  ,
  output logic        equality_check
`endif
);

  state_e              state_q;
  logic [DATA_W-1:0]   a_q, b_q, f_q;
  logic [3:0]          sel_q;
  logic                m_q, carry_q;
  logic [IDX_W-1:0]    idx_q;
  logic                p_acc_q, g_acc_q, p_acc_d, g_acc_d;
  logic                busy_q, done_q, cn4_q, p_q, g_q;
  logic [SLICE_W-1:0]  a_nib, b_nib, s_f;
  logic                s_cout, s_p, s_g;

  assign a_nib = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign b_nib = b_q[int'(idx_q)*SLICE_W +: SLICE_W];

  alu_4bit u_slice (
    .A      (a_nib),
    .B      (b_nib),
    .ALU_Sel(sel_q),
    .M      (m_q),
    .cin    (carry_q),
    .F      (s_f),
    .cout   (s_cout),
    .p      (s_p),
    .g      (s_g)
  );

  // Fold the current slice into the running group propagate/generate.
  always_comb begin
    p_acc_d = p_acc_q & s_p;
    g_acc_d = s_g | (s_p & g_acc_q);
  end

`ifdef ALU_SERIAL_EQ_EN
  logic eq_acc_q, eq_acc_d, eq_q;
  // Running nibble-wise equality of the latched operands.
  always_comb eq_acc_d = eq_acc_q & (a_nib == b_nib);
  assign equality_check = eq_q;
`endif

  // Controller and datapath; busy/done are registered from the state so they trail it by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      sel_q   <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      p_acc_q <= 1'b0;
      g_acc_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cn4_q   <= 1'b0;
      p_q     <= 1'b0;
      g_q     <= 1'b0;
`ifdef ALU_SERIAL_EQ_EN
      eq_acc_q <= 1'b0;
      eq_q     <= 1'b0;
`endif
    end else begin
      busy_q <= (state_q != IDLE);
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: if (start) begin
          a_q     <= A;
          b_q     <= B;
          sel_q   <= ALU_Sel;
          m_q     <= M;
          carry_q <= cin;
          idx_q   <= '0;
          p_acc_q <= 1'b1;
          g_acc_q <= 1'b0;
`ifdef ALU_SERIAL_EQ_EN
          eq_acc_q <= 1'b1;
`endif
          state_q <= RUN;
        end
        RUN: begin
          f_q[int'(idx_q)*SLICE_W +: SLICE_W] <= s_f;
          carry_q <= s_cout;
          p_acc_q <= p_acc_d;
          g_acc_q <= g_acc_d;
`ifdef ALU_SERIAL_EQ_EN
          eq_acc_q <= eq_acc_d;
`endif
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IDX_W'(NUM_SLICES - 1)) state_q <= DONE;
        end
        DONE: begin
          // carry_q now holds the top slice carry-out.
          cn4_q   <= ~carry_q;
          p_q     <= p_acc_q;
          g_q     <= g_acc_q;
`ifdef ALU_SERIAL_EQ_EN
          eq_q    <= eq_acc_q;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign F    = f_q;
  assign Cn4  = cn4_q;
  assign P    = p_q;
  assign G    = g_q;

endmodule

// File: tb/tb_alu_16bit_serial.sv
// Directed bench for alu_16bit_serial; expected values are hand-derived for the
// 74181-style slice (ALU_Sel=9/M=0 is A plus B plus cin, 6/M=0 is A minus B minus 1
// plus cin, 6/M=1 is XOR). Covers ALU_SERIAL_EQ_EN when defined.
module tb_alu_16bit_serial;

  logic        clk = 1'b0;
  logic        rst, start, M, cin;
  logic [15:0] A, B;
  logic [3:0]  ALU_Sel;
  logic        busy, done, Cn4, P, G;
  logic [15:0] F;
`ifdef ALU_SERIAL_EQ_EN
  logic        equality_check;
`endif

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  alu_16bit_serial dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .ALU_Sel(ALU_Sel),
    .M      (M),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .F      (F),
    .Cn4    (Cn4),
    .P      (P),
    .G      (G)
`ifdef ALU_SERIAL_EQ_EN
    ,
    .equality_check(equality_check)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One posedge per call; drive and sample on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] sel, input logic m, input logic c);
    A = a; B = b; ALU_Sel = sel; M = m; cin = c; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      step();
      seen = done;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic chk_res(input string tag, input logic [15:0] f,
                         input logic c4, input logic p, input logic g);
    chk({tag, "_F"},   32'(F),   32'(f));
    chk({tag, "_Cn4"}, 32'(Cn4), 32'(c4));
    chk({tag, "_P"},   32'(P),   32'(p));
    chk({tag, "_G"},   32'(G),   32'(g));
  endtask

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; ALU_Sel = '0; M = 1'b0; cin = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
`ifdef ALU_SERIAL_EQ_EN
    chk("rst_eq", 32'(equality_check), 32'd0);
`endif
    rst = 1'b0;
    while (cyc < 9) step();

    // Latency: accepted at edge 10; busy after 11..15, done only after 15.
    launch(16'h1234, 16'h0F0F, 4'd9, 1'b0, 1'b0);
    chk("lat_accept_edge", 32'(cyc), 32'd10);
    chk("lat_busy0", 32'(busy), 32'd0);
    chk("lat_done0", 32'(done), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("lat_busy%0d", k), 32'(busy), 32'((k <= 5) ? 1 : 0));
      chk($sformatf("lat_done%0d", k), 32'(done), 32'((k == 5) ? 1 : 0));
    end
    chk_res("add", 16'h2143, 1'b1, 1'b0, 1'b0);

    // Full carry ripple through all four slices.
    launch(16'hFFFF, 16'h0001, 4'd9, 1'b0, 1'b0);
    wait_done("carry_done");
    chk_res("carry", 16'h0000, 1'b0, 1'b0, 1'b1);

    // All slices propagate: P=1, G=0, carry comes only from cin.
    launch(16'h0000, 16'hFFFF, 4'd9, 1'b0, 1'b1);
    wait_done("prop_done");
    chk_res("prop", 16'h0000, 1'b0, 1'b1, 1'b0);

    // Subtract (A minus B minus 1 plus cin=1).
    launch(16'h1234, 16'h0F0F, 4'd6, 1'b0, 1'b1);
    wait_done("sub_done");
    chk_res("sub", 16'h0325, 1'b0, 1'b0, 1'b1);

    // Logic mode XOR; carry outputs still follow the arithmetic pair.
    launch(16'h1234, 16'h0F0F, 4'd6, 1'b1, 1'b0);
    wait_done("xor_done");
    chk_res("xor", 16'h1D3B, 1'b0, 1'b0, 1'b1);

    // Start during RUN is ignored: one done, result of the first operands.
    launch(16'h1234, 16'h0F0F, 4'd9, 1'b0, 1'b0);
    step(); step();
    A = 16'hFFFF; B = 16'h0001; ALU_Sel = 4'd6; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    dcount = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done) dcount++;
    end
    chk("ign_done_count", 32'(dcount), 32'd1);
    chk("ign_F", 32'(F), 32'h2143);

    // Reset at slice index 2 aborts silently.
    launch(16'hFFFF, 16'h0001, 4'd9, 1'b0, 1'b0);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk_res("mrst", 16'h0000, 1'b0, 1'b0, 1'b0);
    dcount = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done || busy) dcount++;
    end
    chk("mrst_no_activity", 32'(dcount), 32'd0);
    launch(16'h1234, 16'h0F0F, 4'd9, 1'b0, 1'b0);
    wait_done("mrst_after_done");
    chk_res("mrst_after", 16'h2143, 1'b1, 1'b0, 1'b0);

    // Hold: inputs wander without start, results stay put.
    dcount = 0;
    for (int k = 0; k < 20; k++) begin
      A = 16'(k * 16'h1357); B = 16'(~k); ALU_Sel = 4'(k);
      step();
      if (F !== 16'h2143 || Cn4 !== 1'b1 || P !== 1'b0 || G !== 1'b0) dcount++;
    end
    chk("hold_changes", 32'(dcount), 32'd0);
    chk_res("hold", 16'h2143, 1'b1, 1'b0, 1'b0);

`ifdef ALU_SERIAL_EQ_EN
    launch(16'hA5A5, 16'hA5A5, 4'd9, 1'b0, 1'b0);
    wait_done("eq1_done");
    chk("eq_equal", 32'(equality_check), 32'd1);
    launch(16'hA5A5, 16'hA5A4, 4'd9, 1'b0, 1'b0);
    wait_done("eq0_done");
    chk("eq_differ", 32'(equality_check), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_16bit_serial.md
ALU_16BIT_SERIAL -- requirements
Module: alu_16bit_serial

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock; the only clock.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: start  input  1  request pulse, sampled only in IDLE.
REQ-004 SHALL have: A, B  input  16 each  operands, sampled with start.
REQ-005 SHALL have: ALU_Sel  input  4  function select; M  input  1  mode; cin  input  1  slice-0 carry in.
REQ-006 SHALL have: busy  output  1  operation in progress.
REQ-007 SHALL have: done  output  1  one-cycle result-valid strobe.
REQ-008 SHALL have: F  output  16  result.
REQ-009 SHALL have: Cn4  output  1  inverted final slice carry.
REQ-010 SHALL have: P, G  output  1 each  group propagate and generate.
REQ-011 SHALL have, with ALU_SERIAL_EQ_EN only: equality_check  output  1  latched A equals latched B.

Function
REQ-012 SHALL compute the same 16-bit operation as four chained alu_4bit slices, using one slice instance over four cycles.
REQ-013 SHALL use FSM states IDLE, RUN, DONE.
REQ-014 IDLE: start=1 SHALL latch A, B, ALU_Sel, M and cin, clear slice index to 0, and move to RUN.
REQ-015 RUN, each cycle: the slice SHALL process latched nibble [4i+3:4i] with the carry register.
- It SHALL write F[4i+3:4i].
- It SHALL store the slice carry-out into the carry register.
- It SHALL fold p and g: P_acc &= p; G_acc = g | (p & G_acc).
- It SHALL increment i.
REQ-016 After i=3 is processed, SHALL go to DONE; in DONE, done=1 for exactly one cycle, then IDLE.
REQ-017 Latency SHALL be: start sampled at edge N, done high in the cycle after edge N+5; busy high after edges N+1 through N+5.
REQ-018 start SHALL be ignored in RUN and DONE; no queuing.
REQ-019 F, Cn4, P and G SHALL hold their final values from DONE until the next accepted start.
REQ-020 F nibbles SHALL update progressively during RUN; outputs are valid only at done.
REQ-021 Cn4 SHALL equal the inverted carry-out of slice 3.
REQ-022 The carry register SHALL be loaded with latched cin at start acceptance; operand changes after acceptance SHALL have no effect.

Reset
REQ-023 rst=1 at any clock edge SHALL force IDLE with busy=0, done=0, F=0, Cn4=0, P=0, G=0 and equality_check=0.
- This SHALL abort any operation in progress without asserting done.
REQ-024 rst SHALL take priority over start in the same cycle.

Configuration
REQ-025 With ALU_SERIAL_EQ_EN defined: an equality flag SHALL be initialised to 1 at start acceptance and ANDed with (A nibble == B nibble) each RUN cycle.
- equality_check SHALL present this flag from DONE onward, held like F.
REQ-026 Without ALU_SERIAL_EQ_EN: the equality_check port and its logic SHALL be absent.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE), slice width 4 and slice count 4.
REQ-028 SHALL instantiate exactly one sub-module, alu_4bit, with its existing port order.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Latency: start with A=16'h1234, B=16'h0F0F at edge 10 -> busy after edges 11-15, done only in the cycle after edge 15; F, Cn4, P and G equal a four-slice combinational chain of alu_4bit.
- Carry chain: A=16'hFFFF, B=16'h0001, add selection, cin chosen to add -> carry ripples through all four slices; F and Cn4 match the combinational chain.
- Equality (macro on): A=B=16'hA5A5 -> equality_check=1; A=16'hA5A5, B=16'hA5A4 -> equality_check=0.
- Ignored start: start pulsed during RUN with different operands -> result reflects the first operands; exactly one done.
- Mid-operation reset: rst during RUN at i=2 -> next cycle IDLE, all outputs 0, no done; a subsequent start completes normally.
- Hold: after done, change A, B and ALU_Sel without start for 20 cycles -> F, Cn4, P and G unchanged.
